switch_bounce_generator: RTL
============================

// Module: switch_bounce_generator
// PURPOSE
// - Drives a realistic mechanical-switch waveform: takes a clean level command, emits a
//   bursty, LFSR-randomised toggle train that settles on the commanded level.
// - Feeds the switch_in of our debouncers in self-test and emulation builds; the transmit
//   end of the raw-switch interface.
// PARAMETERS
// - RESET_LEVEL   1'b0       bounce_out level at reset
// - GAP_WIDTH     16         width of the inter-toggle gap counter
// - MIN_GAP       50         minimum cycles between toggles (>=1)
// - GAP_MASK      16'h00FF   random gap extension = lfsr[GAP_WIDTH-1:0] & GAP_MASK
// - SETTLE_COUNT  1000       cycles target level is held after last toggle before done (>=1)
// - LFSR_SEED     16'hACE1   LFSR reset value; 0 is replaced by 16'h0001
// PORTS
// - clk          in   1  system clock
// - rst_n        in   1  asynchronous active-low reset
// - cmd_valid    in   1  command request
// - cmd_ready    out  1  high in IDLE; command accepted when cmd_valid && cmd_ready at clk edge
// - cmd_level    in   1  target settled level, sampled on accept
// - cfg_bounces  in   4  bounce count N, sampled on accept (0 = clean step)
// - bounce_out   out  1  emulated raw switch signal
// - busy         out  1  high in BOUNCE or SETTLE
// - done         out  1  one-cycle pulse when a command completes
// BEHAVIOUR
// - Single clock, asynchronous active-low reset. Reset (incl. mid-operation): state=IDLE,
//   bounce_out=RESET_LEVEL, busy=0, done=0, cmd_ready=1, LFSR=seed, counters=0.
// - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every cycle, never zero.
// - gap = MIN_GAP + (lfsr & GAP_MASK), computed GAP_WIDTH+1 bits, saturated to all-ones.
// - States: IDLE, BOUNCE, SETTLE. cmd_ready = (state==IDLE); registered outputs.
// - IDLE, accept at edge T:
//   - cmd_level == bounce_out: no toggle, stay IDLE, done=1 in cycle T+1.
//   - else: load remaining toggles = 2N+1, go BOUNCE; first toggle visible in cycle T+1.
// - BOUNCE: each toggle inverts bounce_out, decrements remaining, reloads gap; next toggle
//   after exactly gap cycles. Odd toggle count guarantees final level = cmd_level.
//   Final toggle at cycle L -> SETTLE, settle counter loaded with SETTLE_COUNT.
// - SETTLE: bounce_out held at target; at cycle L+SETTLE_COUNT state=IDLE, done=1,
//   cmd_ready=1 (same cycle). done low otherwise.
// - cmd_valid while busy ignored, no queueing; cmd_level/cfg_bounces changes ignored.
// - Back-to-back: command accepted in the done cycle starts a new burst normally.
// CONFIGURATION
// - SWITCH_BOUNCE_GLITCH_EN defined: in SETTLE, when lfsr[15:12]==4'h0, bounce_out is
//   inverted for exactly one cycle then restored; never in the first or last SETTLE cycle;
//   settle counter and done timing unchanged. Undefined: SETTLE output strictly constant.
// TESTING (MIN_GAP=4, GAP_MASK=0, SETTLE_COUNT=10 unless noted)
// - Reset: rst_n low mid-BOUNCE -> bounce_out=0, busy=0, done=0, cmd_ready=1 immediately.
// - level=1, N=2 accepted at T -> toggles at T+1,5,9,13,17, bounce_out=1 after T+17,
//   done at T+27, busy high T+1..T+26.
// - level=1, N=0 -> single rise at T+1, done at T+11; no further transitions.
// - level=0 while bounce_out=0 -> no transition, done at T+1, cmd_ready stays 1.
// - cmd_valid held high through burst -> exactly one burst per done; re-accept at done cycle.
// - GAP_MASK=15, N=15, two runs same seed -> all gaps in [4,19], identical traces;
//   with SWITCH_BOUNCE_GLITCH_EN only 1-cycle glitches in SETTLE, final level correct.

Source files
------------

// File: rtl/switch_bounce_generator.sv
// Emulated mechanical switch: turns a clean level command into an LFSR-randomised toggle burst
// that settles on the commanded level. Optional settle-phase glitches: SWITCH_BOUNCE_GLITCH_EN.
module switch_bounce_generator #(
    parameter logic                 RESET_LEVEL  = 1'b0,
    parameter int                   GAP_WIDTH    = 16,
    parameter int                   MIN_GAP      = 50,
    parameter logic [GAP_WIDTH-1:0] GAP_MASK     = 'h00FF,
    parameter int                   SETTLE_COUNT = 1000,
    parameter logic [15:0]          LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_level,
    input  logic [3:0] cfg_bounces,
    output logic       bounce_out,
    output logic       busy,
    output logic       done
);

    localparam int                   SW          = $clog2(SETTLE_COUNT + 1);
    localparam logic [15:0]          SEED        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [GAP_WIDTH:0]   MIN_GAP_W   = (GAP_WIDTH + 1)'(MIN_GAP);
    localparam logic [SW-1:0]        SETTLE_LOAD = SW'(SETTLE_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 bounce_q, bounce_d;
    logic [4:0]           remaining_q, remaining_d;
    logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [SW-1:0]        settle_cnt_q, settle_cnt_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic [15:0]          lfsr_q, lfsr_d;
`ifdef SWITCH_BOUNCE_GLITCH_EN
    logic                 glitch_q, glitch_d;
`endif

    logic [GAP_WIDTH-1:0] lfsr_slice;
    logic [GAP_WIDTH:0]   gap_sum;
    logic [GAP_WIDTH-1:0] gap;

    // Galois form of x^16+x^14+x^13+x^11; a non-zero seed never reaches zero.
    assign lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign lfsr_slice = GAP_WIDTH'(lfsr_q);
    assign gap_sum    = MIN_GAP_W + {1'b0, lfsr_slice & GAP_MASK};
    assign gap        = gap_sum[GAP_WIDTH] ? '1 : gap_sum[GAP_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bounce_q     <= RESET_LEVEL;
            remaining_q  <= '0;
            gap_cnt_q    <= '0;
            settle_cnt_q <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
            lfsr_q       <= SEED;
`ifdef SWITCH_BOUNCE_GLITCH_EN
            glitch_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bounce_q     <= bounce_d;
            remaining_q  <= remaining_d;
            gap_cnt_q    <= gap_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            lfsr_q       <= lfsr_d;
`ifdef SWITCH_BOUNCE_GLITCH_EN
            glitch_q     <= glitch_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        bounce_d     = bounce_q;
        remaining_d  = remaining_q;
        gap_cnt_d    = gap_cnt_q;
        settle_cnt_d = settle_cnt_q;
        done_d       = 1'b0;
`ifdef SWITCH_BOUNCE_GLITCH_EN
        glitch_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_level == bounce_q) begin
                        done_d = 1'b1;
                    end else begin
                        // The first of the 2N+1 toggles happens on the accepting edge.
                        bounce_d    = ~bounce_q;
                        remaining_d = {cfg_bounces, 1'b0};
                        if (cfg_bounces == 4'd0) begin
                            state_d      = SETTLE;
                            settle_cnt_d = SETTLE_LOAD;
                        end else begin
                            state_d   = BOUNCE;
                            gap_cnt_d = gap;
                        end
                    end
                end
            end
            BOUNCE: begin
                if (gap_cnt_q <= 1) begin
                    bounce_d    = ~bounce_q;
                    remaining_d = remaining_q - 5'd1;
                    if (remaining_q == 5'd1) begin
                        state_d      = SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                    end else begin
                        gap_cnt_d = gap;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt_q <= 1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
`ifdef SWITCH_BOUNCE_GLITCH_EN
                    // Glitch only lands on cycles with count >= 2, so the last settle cycle stays clean.
                    if (glitch_q) begin
                        bounce_d = ~bounce_q;
                    end else if (lfsr_q[15:12] == 4'h0 && int'(settle_cnt_q) >= 3) begin
                        bounce_d = ~bounce_q;
                        glitch_d = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    assign cmd_ready  = ready_q;
    assign bounce_out = bounce_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
